// File: rtl/bus_switch_port_pkg.sv
// rtl/bus_switch_port_pkg.sv - shared CPU bus widths, register offsets and peripheral base addresses
package bus_switch_port_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int NUM_REGS = 4;

  // Register offsets within a peripheral's 4-address window
  localparam logic [1:0] OFF_LEVEL = 2'd0;
  localparam logic [1:0] OFF_RISE  = 2'd1;
  localparam logic [1:0] OFF_MASK  = 2'd2;
  localparam logic [1:0] OFF_FALL  = 2'd3;

  // Peripheral base addresses on the shared bus
  localparam logic [ADDR_W-1:0] SWITCH_BASE = 8'hC0;

  // Distance of a bus address from a peripheral base; wraps for addresses below the base
  function automatic logic [ADDR_W-1:0] reg_offset(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/Generic_counter.sv
// rtl/Generic_counter.sv - free-running wrap counter with a terminal-count trigger
module Generic_counter #(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = 9
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  output logic TRIG_OUT
);

  localparam logic [COUNTER_WIDTH-1:0] MAX_VAL = COUNTER_MAX[COUNTER_WIDTH-1:0];
  localparam logic [COUNTER_WIDTH-1:0] ONE     = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic [COUNTER_WIDTH-1:0] count;

  // Count 0..MAX_VAL and wrap back to zero
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (ENABLE) begin
      if (count == MAX_VAL) count <= '0;
      else                  count <= count + ONE;
    end
  end

  assign TRIG_OUT = ENABLE && (count == MAX_VAL);

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - 2-flop synchroniser, tick-paced sampling and 2-sample agreement filter
module switch_debouncer
  import bus_switch_port_pkg::*;
#(
  parameter int DEBOUNCE_MAX = 99999,
  parameter int TICK_W       = 17
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] SWITCH_IN,
  output logic [DATA_W-1:0] LEVEL
);

  logic [DATA_W-1:0] sync_1;
  logic [DATA_W-1:0] sync_2;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] agree;
  logic              tick;

  Generic_counter #(
    .COUNTER_WIDTH(TICK_W),
    .COUNTER_MAX  (DEBOUNCE_MAX)
  ) u_tick (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENABLE  (1'b1),
    .TRIG_OUT(tick)
  );

  // Bring the asynchronous switch levels into the clock domain
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= SWITCH_IN;
      sync_2 <= sync_1;
    end
  end

  // A bit is accepted only when two consecutive tick samples agree
  assign agree = ~(sync_2 ^ sample);

  // On each tick store the new sample and update the agreeing level bits
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sample <= '0;
      LEVEL  <= '0;
    end else if (tick) begin
      sample <= sync_2;
      LEVEL  <= (sync_2 & agree) | (LEVEL & ~agree);
    end
  end

endmodule

// File: rtl/bus_switch_port.sv
// rtl/bus_switch_port.sv - switch input peripheral: bus decode, edge flags, interrupt and tristate read-back (optional SWITCH_FALL_EDGE_EN)
module bus_switch_port
  import bus_switch_port_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR    = SWITCH_BASE,
  parameter int                DEBOUNCE_MAX = 99999,
  parameter int                TICK_W       = 17
) (
  input  logic              CLK,
  input  logic              RESET,
  inout  wire  [DATA_W-1:0] BUS_DATA,
  input  logic [ADDR_W-1:0] BUS_ADDR,
  input  logic              BUS_WE,
  input  logic [DATA_W-1:0] SWITCH_IN,
  output logic              BUS_INTERRUPT_RAISE,
  input  logic              BUS_INTERRUPT_ACK
);

  logic [DATA_W-1:0] level;
  logic [DATA_W-1:0] level_q;
  logic [DATA_W-1:0] rise_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] rise_evt;
  logic [DATA_W-1:0] rise_clr;
  logic [DATA_W-1:0] src_q;
  logic [DATA_W-1:0] src_evt;
  logic [DATA_W-1:0] rd_value;
  logic [DATA_W-1:0] out_q;
  logic [ADDR_W-1:0] offset;
  logic [1:0]        reg_sel;
  logic              in_window;
  logic              mapped;
  logic              rd_hit;
  logic              wr_rise;
  logic              wr_mask;
  logic              hit_q;
  logic              drive_en;

  switch_debouncer #(
    .DEBOUNCE_MAX(DEBOUNCE_MAX),
    .TICK_W      (TICK_W)
  ) u_debouncer (
    .CLK      (CLK),
    .RESET    (RESET),
    .SWITCH_IN(SWITCH_IN),
    .LEVEL    (level)
  );

  assign offset    = reg_offset(BUS_ADDR, BASE_ADDR);
  assign in_window = (offset < ADDR_W'(NUM_REGS));
  assign reg_sel   = offset[1:0];

`ifdef SWITCH_FALL_EDGE_EN
  assign mapped = in_window;
`else
  assign mapped = in_window && (reg_sel != OFF_FALL);
`endif

  assign rd_hit   = mapped && !BUS_WE;
  assign wr_rise  = in_window && BUS_WE && (reg_sel == OFF_RISE);
  assign wr_mask  = in_window && BUS_WE && (reg_sel == OFF_MASK);
  assign rise_evt = level & ~level_q;
  assign rise_clr = wr_rise ? BUS_DATA : '0;

`ifdef SWITCH_FALL_EDGE_EN
  logic [DATA_W-1:0] fall_q;
  logic [DATA_W-1:0] fall_evt;
  logic [DATA_W-1:0] fall_clr;
  logic              wr_fall;

  assign wr_fall  = in_window && BUS_WE && (reg_sel == OFF_FALL);
  assign fall_evt = ~level & level_q;
  assign fall_clr = wr_fall ? BUS_DATA : '0;
  assign src_q    = rise_q | fall_q;
  assign src_evt  = rise_evt | fall_evt;

  // Sticky falling-edge flags; a new edge beats a same-cycle clear
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) fall_q <= '0;
    else        fall_q <= (fall_q & ~fall_clr) | fall_evt;
  end
`else
  assign src_q   = rise_q;
  assign src_evt = rise_evt;
`endif

  // Level history, sticky rising-edge flags and the interrupt mask
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      level_q <= '0;
      rise_q  <= '0;
      mask_q  <= '0;
    end else begin
      level_q <= level;
      rise_q  <= (rise_q & ~rise_clr) | rise_evt;
      if (wr_mask) mask_q <= BUS_DATA;
    end
  end

  // Raise only for source bits that go from clear to set while enabled; ACK loses to a new hit
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_q               <= 1'b0;
      BUS_INTERRUPT_RAISE <= 1'b0;
    end else begin
      hit_q               <= |(src_evt & ~src_q & mask_q);
      BUS_INTERRUPT_RAISE <= hit_q | (BUS_INTERRUPT_RAISE & ~BUS_INTERRUPT_ACK);
    end
  end

  // Select the register addressed by the current read
  always_comb begin
    rd_value = '0;
    case (reg_sel)
      OFF_LEVEL: rd_value = level;
      OFF_RISE:  rd_value = rise_q;
      OFF_MASK:  rd_value = mask_q;
`ifdef SWITCH_FALL_EDGE_EN
      OFF_FALL:  rd_value = fall_q;
`else
      OFF_FALL:  rd_value = '0;
`endif
    endcase
  end

  // Registered read data and drive enable give one-cycle read latency
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      drive_en <= 1'b0;
      out_q    <= '0;
    end else begin
      drive_en <= rd_hit;
      if (rd_hit) out_q <= rd_value;
    end
  end

  assign BUS_DATA = drive_en ? out_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_switch_port.sv
// tb/tb_bus_switch_port.sv - self-checking bench for bus_switch_port
module tb_bus_switch_port;

  localparam logic [7:0] BASE    = 8'hC0;
  localparam int         DMAX    = 9;
  localparam int         TICKS   = DMAX + 1;
  localparam int         LAT_MAX = 2 * TICKS + 3;
  localparam int         SETTLE  = 30;

  logic       CLK       = 1'b0;
  logic       RESET     = 1'b0;
  logic [7:0] BUS_ADDR  = 8'h00;
  logic       BUS_WE    = 1'b0;
  logic [7:0] SWITCH_IN = 8'h00;
  logic       ACK       = 1'b0;
  logic       RAISE;
  logic       tb_oe     = 1'b0;
  logic [7:0] tb_data   = 8'h00;
  wire  [7:0] BUS_DATA;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  assign BUS_DATA = tb_oe ? tb_data : 8'hzz;

  bus_switch_port #(
    .BASE_ADDR   (BASE),
    .DEBOUNCE_MAX(DMAX),
    .TICK_W      (4)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .BUS_DATA           (BUS_DATA),
    .BUS_ADDR           (BUS_ADDR),
    .BUS_WE             (BUS_WE),
    .SWITCH_IN          (SWITCH_IN),
    .BUS_INTERRUPT_RAISE(RAISE),
    .BUS_INTERRUPT_ACK  (ACK)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_drv;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic bus_driven();
    return dut.drive_en;
  endfunction

  task automatic add_vec(input logic we, input logic [7:0] a, input logic [7:0] wd,
                         input logic drv, input logic [7:0] rd);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.exp_drv = drv; v.exp_data = rd;
    vecs.push_back(v);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a; BUS_WE = 1'b1; tb_oe = 1'b1; tb_data = d;
    @(posedge CLK); #1;
    check("no_drive_on_write", bus_driven(), 1'b0);
    BUS_WE = 1'b0; tb_oe = 1'b0; BUS_ADDR = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic drv);
    BUS_ADDR = a; BUS_WE = 1'b0; tb_oe = 1'b0;
    @(posedge CLK); #1;
    drv = bus_driven();
    d   = BUS_DATA;
    BUS_ADDR = 8'h00;
    @(posedge CLK); #1;
    check("release_after_read", bus_driven(), 1'b0);
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       drv;
    bus_read(a, d, drv);
    check({name, "_drv"}, drv, 1'b1);
    if (drv) check(name, d, exp);
  endtask

  task automatic settle();
    repeat (SETTLE) @(posedge CLK);
    #1;
  endtask

  task automatic ack_pulse();
    ACK = 1'b1;
    @(posedge CLK); #1;
    ACK = 1'b0;
  endtask

  task automatic wait_phase();
    for (int i = 0; i < TICKS && (cyc % TICKS) != 0; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  // Poll a register every cycle until bit b is set; returns the edge where it changed
  task automatic poll_bit(input logic [7:0] a, input int b, output int set_edge,
                          output logic found, output logic raise_before, output logic raise_at);
    logic prev;
    found = 1'b0; set_edge = 0; raise_before = 1'b0; raise_at = 1'b0;
    prev = RAISE;
    BUS_ADDR = a; BUS_WE = 1'b0;
    for (int i = 0; i < LAT_MAX + 4; i++) begin
      @(posedge CLK); #1;
      if (bus_driven() && BUS_DATA[b]) begin
        found = 1'b1; set_edge = cyc - 1; raise_before = prev; raise_at = RAISE;
        break;
      end
      prev = RAISE;
    end
    BUS_ADDR = 8'h00;
    @(posedge CLK); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       drv, found, rb, ra;
    int         start, sedge, dly;
    logic [7:0] sw_m, rise_m, fall_m, mask_m, up, dn, newly, clr, nm;
    logic       raise_m;

    // Reset state and asynchronous release of a read in progress
    repeat (3) @(posedge CLK);
    #1;
    check("reset_raise", RAISE, 1'b0);
    check("reset_no_drive", bus_driven(), 1'b0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    BUS_ADDR = BASE;
    @(posedge CLK); #1;
    check("read_drive_before_reset", bus_driven(), 1'b1);
    #2 RESET = 1'b0;
    #1 check("async_reset_release", bus_driven(), 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b1; BUS_ADDR = 8'h00;
    @(posedge CLK); #1;
    check("idle_no_drive", bus_driven(), 1'b0);

    // Register map table from reset state
    add_vec(0, BASE + 8'd0, 8'h00, 1, 8'h00);
    add_vec(0, BASE + 8'd1, 8'h00, 1, 8'h00);
    add_vec(0, BASE + 8'd2, 8'h00, 1, 8'h00);
    add_vec(0, 8'h00,       8'h00, 0, 8'h00);
    add_vec(1, BASE + 8'd2, 8'hA5, 0, 8'h00);
    add_vec(0, BASE + 8'd2, 8'h00, 1, 8'hA5);
    add_vec(1, BASE + 8'd0, 8'hFF, 0, 8'h00);
    add_vec(0, BASE + 8'd0, 8'h00, 1, 8'h00);
    add_vec(1, BASE + 8'd1, 8'hFF, 0, 8'h00);
    add_vec(0, BASE + 8'd1, 8'h00, 1, 8'h00);
    add_vec(1, BASE + 8'd3, 8'hFF, 0, 8'h00);
`ifdef SWITCH_FALL_EDGE_EN
    add_vec(0, BASE + 8'd3, 8'h00, 1, 8'h00);
`else
    add_vec(0, BASE + 8'd3, 8'h00, 0, 8'h00);
`endif
    add_vec(0, BASE - 8'd1, 8'h00, 0, 8'h00);
    add_vec(0, BASE + 8'd4, 8'h00, 0, 8'h00);
    add_vec(1, BASE + 8'd2, 8'h00, 0, 8'h00);
    add_vec(0, BASE + 8'd2, 8'h00, 1, 8'h00);
    foreach (vecs[i]) begin
      if (vecs[i].we) begin
        bus_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        bus_read(vecs[i].addr, d, drv);
        check($sformatf("vec%0d_drv", i), drv, vecs[i].exp_drv);
        if (vecs[i].exp_drv && drv) check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      end
    end
    check("table_raise", RAISE, 1'b0);

    // Debounce latency, rise capture and glitch rejection
    wait_phase();
    SWITCH_IN = 8'h05; start = cyc;
    poll_bit(BASE + 8'd0, 0, sedge, found, rb, ra);
    check("level_found", found, 1'b1);
    if (found) check("level_latency_ok", (sedge - start) <= LAT_MAX, 1'b1);
    read_check("level_05", BASE + 8'd0, 8'h05);
    read_check("rise_05", BASE + 8'd1, 8'h05);
    SWITCH_IN = 8'h85;
    repeat (5) @(posedge CLK);
    #1 SWITCH_IN = 8'h05;
    settle();
    read_check("glitch_level", BASE + 8'd0, 8'h05);
    read_check("glitch_rise", BASE + 8'd1, 8'h05);

    // Interrupt raise timing, ACK, unmasked edge, mask of already-set bits
    bus_write(BASE + 8'd1, 8'hFF);
    SWITCH_IN = 8'h04;
    settle();
`ifdef SWITCH_FALL_EDGE_EN
    bus_write(BASE + 8'd3, 8'hFF);
`endif
    bus_write(BASE + 8'd2, 8'h01);
    check("mask_no_raise", RAISE, 1'b0);
    SWITCH_IN = 8'h05;
    poll_bit(BASE + 8'd1, 0, sedge, found, rb, ra);
    check("rise0_found", found, 1'b1);
    check("raise_not_early", rb, 1'b0);
    check("raise_next_cycle", ra, 1'b1);
    ack_pulse();
    check("ack_clears", RAISE, 1'b0);
    SWITCH_IN = 8'h01;
    settle();
    SWITCH_IN = 8'h05;
    settle();
    check("unmasked_no_raise", RAISE, 1'b0);
    read_check("rise_after_irq", BASE + 8'd1, 8'h05);
    bus_write(BASE + 8'd2, 8'hFF);
    repeat (5) @(posedge CLK);
    #1 check("mask_old_flags_no_raise", RAISE, 1'b0);
    bus_write(BASE + 8'd2, 8'h00);

    // W1C and same-cycle clear against a new edge
    bus_write(BASE + 8'd1, 8'h01);
    read_check("w1c_bit0", BASE + 8'd1, 8'h04);
    bus_write(BASE + 8'd1, 8'h04);
    SWITCH_IN = 8'h01;
    settle();
    wait_phase();
    SWITCH_IN = 8'h05; start = cyc;
    poll_bit(BASE + 8'd1, 2, sedge, found, rb, ra);
    check("rise2_found", found, 1'b1);
    dly = sedge - start;
    SWITCH_IN = 8'h01;
    settle();
    bus_write(BASE + 8'd1, 8'hFF);
    wait_phase();
    SWITCH_IN = 8'h05;
    repeat (dly - 1) @(posedge CLK);
    #1;
    BUS_ADDR = BASE + 8'd1; BUS_WE = 1'b1; tb_oe = 1'b1; tb_data = 8'h04;
    @(posedge CLK); #1;
    BUS_WE = 1'b0; tb_oe = 1'b0; BUS_ADDR = 8'h00;
    read_check("set_wins_over_clear", BASE + 8'd1, 8'h04);
    bus_write(BASE + 8'd1, 8'h04);
    read_check("later_clear", BASE + 8'd1, 8'h00);

`ifdef SWITCH_FALL_EDGE_EN
    // Falling-edge flags feed the interrupt when enabled
    bus_write(BASE + 8'd3, 8'hFF);
    ack_pulse();
    bus_write(BASE + 8'd2, 8'h04);
    SWITCH_IN = 8'h01;
    settle();
    read_check("fall_04", BASE + 8'd3, 8'h04);
    check("fall_raise", RAISE, 1'b1);
`endif

    // Randomized held-level sequences against a flag/interrupt model
    bus_write(BASE + 8'd1, 8'hFF);
`ifdef SWITCH_FALL_EDGE_EN
    bus_write(BASE + 8'd3, 8'hFF);
`endif
    bus_write(BASE + 8'd2, 8'h00);
    ack_pulse();
    sw_m = SWITCH_IN; rise_m = 8'h00; fall_m = 8'h00; mask_m = 8'h00; raise_m = 1'b0;
    for (int it = 0; it < 25; it++) begin
      nm = 8'($urandom);
      up = nm & ~sw_m;
      dn = ~nm & sw_m;
`ifdef SWITCH_FALL_EDGE_EN
      newly = (up | dn) & ~(rise_m | fall_m) & mask_m;
      fall_m = fall_m | dn;
`else
      newly = up & ~rise_m & mask_m;
`endif
      rise_m = rise_m | up;
      if (newly != 8'h00) raise_m = 1'b1;
      SWITCH_IN = nm; sw_m = nm;
      settle();
      check($sformatf("rnd%0d_raise", it), RAISE, raise_m);
      read_check($sformatf("rnd%0d_level", it), BASE + 8'd0, sw_m);
      read_check($sformatf("rnd%0d_rise", it), BASE + 8'd1, rise_m);
`ifdef SWITCH_FALL_EDGE_EN
      read_check($sformatf("rnd%0d_fall", it), BASE + 8'd3, fall_m);
      clr = 8'($urandom);
      bus_write(BASE + 8'd3, clr);
      fall_m = fall_m & ~clr;
`endif
      if ($urandom_range(1, 0) == 1) begin
        ack_pulse();
        raise_m = 1'b0;
        check($sformatf("rnd%0d_ack", it), RAISE, raise_m);
      end
      clr = 8'($urandom);
      bus_write(BASE + 8'd1, clr);
      rise_m = rise_m & ~clr;
      if ($urandom_range(1, 0) == 1) begin
        mask_m = 8'($urandom);
        bus_write(BASE + 8'd2, mask_m);
        read_check($sformatf("rnd%0d_mask", it), BASE + 8'd2, mask_m);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_switch_port.md
Name: bus_switch_port

Overview:
- Memory-mapped input peripheral on the 8-bit shared CPU bus; the read-side counterpart of the write-only display registers.
- Synchronises and debounces 8 slide switches, captures rising edges, and returns levels and flags to the CPU on bus reads by driving BUS_DATA.
- Raises a bus interrupt on newly captured, unmasked edges.

Parameters:
- BASE_ADDR, 8'hC0, first of 4 consecutive register addresses.
- DEBOUNCE_MAX, 99999, tick period minus 1 in CLK cycles (1 ms at 100 MHz).
- TICK_W, 17, width of the debounce tick counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BUS_DATA  inout  8  shared bus data; driven only during a matched read, high-Z otherwise.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  1 = CPU write, 0 = read/idle.
- SWITCH_IN  in  8  raw asynchronous switch levels.
- BUS_INTERRUPT_RAISE  out  1  interrupt request, level.
- BUS_INTERRUPT_ACK  in  1  single-cycle acknowledge from the CPU.

Behaviour:
- Register map: BASE+0 LEVEL (RO, debounced levels); BASE+1 RISE (R, W1C edge flags); BASE+2 MASK (R/W interrupt mask); BASE+3 FALL (see Optional Feature).
- Reset (RESET=0): LEVEL, RISE, MASK, synchroniser flops, sample register, tick counter and BUS_INTERRUPT_RAISE are all 0. The drive enable is 0, so BUS_DATA is high-Z.
- Synchroniser: 2 flops per bit on SWITCH_IN.
- Tick: free-running counter 0..DEBOUNCE_MAX; tick=1 for one cycle when the count equals DEBOUNCE_MAX, then the counter wraps to 0.
- Debounce:
  - On tick, the synchronised value is stored in SAMPLE.
  - Each LEVEL bit takes the new sample only if it equals the previous SAMPLE bit, i.e. 2 consecutive agreeing ticks.
  - Worst-case latency from input change to LEVEL change is 2 ticks + 3 cycles.
- Edge capture: any cycle where a LEVEL bit goes 0->1 sets the matching RISE bit. RISE bits are sticky.
- Write (BUS_WE=1, address matched, effective at the posedge):
  - BASE+1: RISE <= RISE & ~BUS_DATA. If a new edge and a clear hit the same bit in the same cycle, set wins.
  - BASE+2: MASK <= BUS_DATA.
  - BASE+0, and BASE+3 when unmapped: ignored.
- Read (BUS_WE=0, address in the mapped range):
  - At the posedge, the output register loads the addressed value and the drive enable is set.
  - BUS_DATA is driven from that edge until the first posedge where the address no longer matches or BUS_WE=1. One-cycle read latency.
  - Reads have no side effects.
- Unmatched address: no drive, no state change.
- Interrupt:
  - BUS_INTERRUPT_RAISE is set in the cycle after any bit is newly set in (RISE & MASK).
  - It is cleared on BUS_INTERRUPT_ACK. If ACK and a new masked edge occur in the same cycle, RAISE stays 1.
  - Clearing RISE by W1C does not drop RAISE; only ACK does.
  - Writing MASK to enable bits that are already set in RISE does not raise.
- Reset mid-read: the drive is released immediately, asynchronously.

Optional Feature:
- SWITCH_FALL_EDGE_EN defined:
  - BASE+3 is FALL, R/W1C, set on LEVEL 1->0, with the same set-wins rule as RISE.
  - Interrupt sources become (RISE|FALL) & MASK.
- Not defined: BASE+3 is unmapped (no drive, writes ignored) and no FALL logic is built.

Decomposition:
- Shared bus package/header holds:
  - DATA_W=8 and ADDR_W=8;
  - register offsets OFF_LEVEL=0, OFF_RISE=1, OFF_MASK=2, OFF_FALL=3;
  - base address constants for all peripherals, SWITCH_BASE=8'hC0.
- Sub-module switch_debouncer contains the synchroniser, tick counter (Generic_counter instance) and 2-sample agreement logic. It outputs the 8-bit LEVEL only.
- The top level holds the bus decode, capture registers, interrupt logic and tristate.

Test Plan:
- Reset, then read BASE+0..2 -> each reads 8'h00, RAISE=0; BUS_DATA is Z on idle address 8'h00 and during writes.
- DEBOUNCE_MAX=9; SWITCH_IN=8'h05 held -> LEVEL=8'h05 within 2 ticks + 3 cycles, RISE=8'h05. A 1-tick glitch to 8'h80 -> LEVEL and RISE bit 7 unchanged.
- MASK<=8'h01, bit 0 rises -> RAISE=1 the next cycle; ACK pulse -> RAISE=0; bit 2 rises (unmasked) -> RAISE stays 0.
- RISE=8'h05; write 8'h01 to BASE+1 -> RISE=8'h04. Same-cycle clear of bit 2 with a new bit-2 edge -> bit 2 stays 1.
- Read BASE+0 held 3 cycles -> BUS_DATA driven from the 1st posedge; address changes to 8'h10 -> Z after the next posedge. Write to BASE+0 -> LEVEL unaffected.
- With SWITCH_FALL_EDGE_EN: LEVEL 8'h05->8'h01 -> FALL=8'h04, and RAISE=1 if MASK[2]=1. Without the macro: read of BASE+3 -> BUS_DATA stays Z.
